// File: rtl/sync_timing_generator.sv
// Video-style sync timing generator: position counter with active/front/sync/back phase FSM.
// Outputs decoded from registers (zero latency vs position); line_end is enable-qualified for chaining.
module sync_timing_generator #(
    parameter int ACTIVE        = 640,
    parameter int FRONT_PORCH   = 16,
    parameter int SYNC_PULSE    = 96,
    parameter int BACK_PORCH    = 48,
    parameter int COUNTER_SIZE  = 11,
    parameter bit SYNC_POLARITY = 1'b0
) (
    input  logic                    control_clock,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    sync,
    output logic                    display_enable,
    output logic [COUNTER_SIZE-1:0] position,
    output logic                    line_end,
    output logic                    frame_start
);

    localparam int TOTAL = ACTIVE + FRONT_PORCH + SYNC_PULSE + BACK_PORCH;

    generate
        if (ACTIVE < 1 || FRONT_PORCH < 1 || SYNC_PULSE < 1 || BACK_PORCH < 1 ||
            COUNTER_SIZE < 1 || COUNTER_SIZE > 62 ||
            longint'(TOTAL) > (longint'(1) << COUNTER_SIZE)) begin : g_bad_params
            $error("sync_timing_generator: invalid timing parameters");
        end
    endgenerate

    // Last count of each phase; the phase changes when that count advances.
    localparam logic [COUNTER_SIZE-1:0] ACTIVE_LAST = COUNTER_SIZE'(ACTIVE - 1);
    localparam logic [COUNTER_SIZE-1:0] FRONT_LAST  = COUNTER_SIZE'(ACTIVE + FRONT_PORCH - 1);
    localparam logic [COUNTER_SIZE-1:0] SYNC_LAST   = COUNTER_SIZE'(ACTIVE + FRONT_PORCH + SYNC_PULSE - 1);
    localparam logic [COUNTER_SIZE-1:0] TOTAL_LAST  = COUNTER_SIZE'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,
        S_FRONT  = 2'd1,
        S_SYNC   = 2'd2,
        S_BACK   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [COUNTER_SIZE-1:0] count_q, count_d;
    logic                    at_last;

    assign at_last = (count_q == TOTAL_LAST);

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            state_q <= S_ACTIVE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (enable) begin
            count_d = at_last ? '0 : count_q + COUNTER_SIZE'(1);
            unique case (state_q)
                S_ACTIVE: if (count_q == ACTIVE_LAST) state_d = S_FRONT;
                S_FRONT:  if (count_q == FRONT_LAST)  state_d = S_SYNC;
                S_SYNC:   if (count_q == SYNC_LAST)   state_d = S_BACK;
                S_BACK:   if (at_last)                state_d = S_ACTIVE;
                default:                              state_d = S_ACTIVE;
            endcase
        end
    end

    // Everything except line_end depends on registers only, so enable cannot glitch them.
    assign sync           = (state_q == S_SYNC) ? SYNC_POLARITY : ~SYNC_POLARITY;
    assign display_enable = (state_q == S_ACTIVE);
    assign position       = count_q;
    assign frame_start    = (count_q == '0);
    assign line_end       = at_last & enable;

endmodule

// File: tb/tb_sync_timing_generator.sv
// Bench for sync_timing_generator: default, small, and chained instances against an arithmetic position model.
// Covers constant, toggling and random enable plus synchronous and asynchronous reset.
module tb_sync_timing_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en_s;
    logic en_one;

    logic        d_sync, d_de, d_le, d_fs;
    logic [10:0] d_pos;
    logic        s_sync, s_de, s_le, s_fs;
    logic [2:0]  s_pos;
    logic        u_sync, u_de, u_le, u_fs;
    logic [3:0]  u_pos;
    logic        c_sync, c_de, c_le, c_fs;
    logic [2:0]  c_pos;

    sync_timing_generator u_default (
        .control_clock(clk), .reset(rst), .enable(en_one),
        .sync(d_sync), .display_enable(d_de), .position(d_pos),
        .line_end(d_le), .frame_start(d_fs)
    );

    sync_timing_generator #(
        .ACTIVE(4), .FRONT_PORCH(1), .SYNC_PULSE(2), .BACK_PORCH(1),
        .COUNTER_SIZE(3), .SYNC_POLARITY(1'b1)
    ) u_small (
        .control_clock(clk), .reset(rst), .enable(en_s),
        .sync(s_sync), .display_enable(s_de), .position(s_pos),
        .line_end(s_le), .frame_start(s_fs)
    );

    sync_timing_generator #(
        .ACTIVE(4), .FRONT_PORCH(1), .SYNC_PULSE(2), .BACK_PORCH(1),
        .COUNTER_SIZE(4), .SYNC_POLARITY(1'b1)
    ) u_up (
        .control_clock(clk), .reset(rst), .enable(en_one),
        .sync(u_sync), .display_enable(u_de), .position(u_pos),
        .line_end(u_le), .frame_start(u_fs)
    );

    sync_timing_generator #(
        .ACTIVE(2), .FRONT_PORCH(1), .SYNC_PULSE(1), .BACK_PORCH(1),
        .COUNTER_SIZE(3), .SYNC_POLARITY(1'b0)
    ) u_chain (
        .control_clock(clk), .reset(rst), .enable(u_le),
        .sync(c_sync), .display_enable(c_de), .position(c_pos),
        .line_end(c_le), .frame_start(c_fs)
    );

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    // Reference positions of each instance
    int md = 0, ms = 0, mu = 0, mc = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_sync(input int p, input int a, input int f, input int s, input logic pol);
        return (p >= a + f && p < a + f + s) ? pol : ~pol;
    endfunction

    task automatic check_all();
        check_val("dflt.pos",  32'(d_pos), 32'(md));
        check_val("dflt.de",   32'(d_de),  32'(md < 640));
        check_val("dflt.sync", 32'(d_sync), 32'(exp_sync(md, 640, 16, 96, 1'b0)));
        check_val("dflt.fs",   32'(d_fs),  32'(md == 0));
        check_val("dflt.le",   32'(d_le),  32'(md == 799));
        check_val("small.pos",  32'(s_pos), 32'(ms));
        check_val("small.de",   32'(s_de),  32'(ms < 4));
        check_val("small.sync", 32'(s_sync), 32'(exp_sync(ms, 4, 1, 2, 1'b1)));
        check_val("small.fs",   32'(s_fs),  32'(ms == 0));
        check_val("small.le",   32'(s_le),  32'((ms == 7) && en_s));
        check_val("up.pos",     32'(u_pos), 32'(mu));
        check_val("up.le",      32'(u_le),  32'(mu == 7));
        check_val("chain.pos",  32'(c_pos), 32'(mc));
        check_val("chain.de",   32'(c_de),  32'(mc < 2));
        check_val("chain.sync", 32'(c_sync), 32'(exp_sync(mc, 2, 1, 1, 1'b0)));
        check_val("chain.fs",   32'(c_fs),  32'(mc == 0));
        check_val("chain.le",   32'(c_le),  32'((mc == 4) && (mu == 7)));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            md = 0; ms = 0; mu = 0; mc = 0;
        end else begin
            if (mu == 7) mc = (mc + 1) % 5;
            mu = (mu + 1) % 8;
            md = (md + 1) % 800;
            if (en_s) ms = (ms + 1) % 8;
        end
        #1;
        case (mode)
            0:       en_s = 1'b1;
            1:       en_s = ~en_s;
            default: en_s = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit found;
        rst    = 1'b1;
        en_s   = 1'b1;
        en_one = 1'b1;
        mode   = 0;
        repeat (2) @(negedge clk);
        check_all();
        // Reset held across enabled edges keeps everything at zero
        step();
        step();
        rst = 1'b0;

        repeat (1700) step();
        mode = 1;
        repeat (40) step();
        mode = 2;
        repeat (300) step();

        // Asynchronous reset while the small instance sits in its sync pulse
        mode  = 0;
        en_s  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (ms == 5) found = 1'b1;
        end
        check_val("wait_pos5", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("async.small.sync", 32'(s_sync), 32'd0);
        check_val("async.small.pos",  32'(s_pos),  32'd0);
        md = 0; ms = 0; mu = 0; mc = 0;
        check_all();
        #1 rst = 1'b0;
        repeat (3) step();
        mode = 2;
        repeat (400) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_timing_generator.md
SYNC_TIMING_GENERATOR -- requirements
Module: sync_timing_generator

Interface
REQ-001 The block SHALL have parameter ACTIVE, default 640: number of counts in the visible region.
REQ-002 The block SHALL have parameter FRONT_PORCH, default 16: counts between the end of the active region and the start of sync.
REQ-003 The block SHALL have parameter SYNC_PULSE, default 96: counts for which sync is asserted.
REQ-004 The block SHALL have parameter BACK_PORCH, default 48: counts between the end of sync and the wrap.
REQ-005 The block SHALL have parameter COUNTER_SIZE, default 11: width of the position counter.
REQ-006 The block SHALL have parameter SYNC_POLARITY, default 0: asserted level of sync (0 = active-low).
REQ-007 control_clock  input  1  sole clock; all state updates on its rising edge.
REQ-008 reset  input  1  reset, asynchronous, active-high.
REQ-009 enable  input  1  advance qualifier; tie to 1 for horizontal use, or to the line_end of another instance for vertical use.
REQ-010 sync  output  1  sync pulse at SYNC_POLARITY level.
REQ-011 display_enable  output  1  high while in the active region.
REQ-012 position  output  COUNTER_SIZE  current count, 0..TOTAL-1.
REQ-013 line_end  output  1  wrap strobe for chaining.
REQ-014 frame_start  output  1  high while position==0.

Function
REQ-015 TOTAL SHALL equal ACTIVE+FRONT_PORCH+SYNC_PULSE+BACK_PORCH, computed at elaboration.
REQ-016 ACTIVE and each porch/pulse parameter SHALL be at least 1, and TOTAL SHALL be at most 2^COUNTER_SIZE; violating parameters SHALL stop elaboration.
REQ-017 The block SHALL hold a registered counter and a 4-state FSM: S_ACTIVE, S_FRONT, S_SYNC, S_BACK.
REQ-018 On a rising edge with enable=1, the counter SHALL increment by 1; at TOTAL-1 it SHALL wrap to 0.
REQ-019 On a rising edge with enable=0, the counter and the FSM SHALL hold.
REQ-020 The FSM SHALL move S_ACTIVE->S_FRONT when count ACTIVE-1 advances.
REQ-021 The FSM SHALL move S_FRONT->S_SYNC when count ACTIVE+FRONT_PORCH-1 advances.
REQ-022 The FSM SHALL move S_SYNC->S_BACK when count ACTIVE+FRONT_PORCH+SYNC_PULSE-1 advances.
REQ-023 The FSM SHALL move S_BACK->S_ACTIVE on the wrap.
REQ-024 The FSM state SHALL always be consistent with position; no other transitions SHALL exist.
REQ-025 sync, display_enable, position and frame_start SHALL be decoded from registered state only, with zero latency relative to position and no glitch path from enable.
REQ-026 sync SHALL equal SYNC_POLARITY in S_SYNC, and ~SYNC_POLARITY otherwise.
REQ-027 display_enable SHALL be 1 exactly in S_ACTIVE.
REQ-028 line_end SHALL equal (position==TOTAL-1) AND enable, combinational, so that a chained instance advances on the same edge as the wrap.
REQ-029 With enable held low at TOTAL-1, line_end SHALL stay low and no wrap SHALL occur.
REQ-030 Chaining: an instance whose enable is driven by another instance's line_end SHALL advance exactly once per TOTAL cycles of the upstream instance.

Reset
REQ-031 While reset=1, regardless of clock or enable: counter=0, state S_ACTIVE.
REQ-032 Resulting reset output values: position=0, display_enable=1, sync=~SYNC_POLARITY, frame_start=1, line_end=0.
REQ-033 Reset asserted mid-line, including during S_SYNC, SHALL deassert sync immediately (asynchronously).
REQ-034 After reset release, the first enabled edge SHALL produce position=1.

Verification
REQ-035 Defaults, enable=1, 1600 cycles -> sync low for positions 656..751 each line; display_enable high for 0..639; line_end once every 800 cycles.
REQ-036 ACTIVE=4, FRONT_PORCH=1, SYNC_PULSE=2, BACK_PORCH=1, SYNC_POLARITY=1 -> position 0..7 repeating; sync=1 at positions 5,6 only; display_enable=1 at 0..3.
REQ-037 Same small parameter set, enable toggling 1/0 each cycle -> each position held 2 cycles; line_end high only in the enabled cycle at position 7.
REQ-038 Two instances chained (upstream enable=1; downstream ACTIVE=2, FRONT_PORCH=1, SYNC_PULSE=1, BACK_PORCH=1) -> downstream position increments on the edge where upstream wraps 7->0; downstream wraps after 40 upstream cycles.
REQ-039 Reset pulsed asynchronously at position 5 of the small set while sync=1 -> sync=0 and position=0 before the next clock edge; counting resumes 1,2,... after release.
REQ-040 Parameters giving TOTAL > 2^COUNTER_SIZE (e.g. COUNTER_SIZE=9 with defaults) -> elaboration error.
